run_sequencer: RTL and testbench
================================

# run_sequencer

Run controller and data-memory owner for the single-cycle core. Holds the core in reset while a host preloads or reads back data memory. Releases the core on a start command and hands it exclusive use of the data-memory port. Detects program completion or a watchdog expiry, then returns memory ownership to the host. Sits between the core top level, the data memory and the host/testbench interface.

## Interface
- MAX_CYCLES, 4096: watchdog limit on RUN cycles.
- CW, 16: cycle-counter width; must satisfy 2^CW > MAX_CYCLES.
- AW, 8: memory address width. DW, 8: memory data width.

Ports:
- Clk  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Start  in  1  run request; sampled in IDLE and DONE only.
- Abort  in  1  cancel run; sampled in RUN only.
- HostReq  in  1  host memory access request; held until granted.
- HostWr  in  1  1 = write, 0 = read.
- HostAddr  in  AW  host address. HostWdat  in  DW  host write data.
- HostGnt  out  1  combinational grant; the access happens in this cycle.
- HostRdat  out  DW  registered read data. HostRvalid  out  1  one-cycle pulse marking HostRdat valid.
- CoreDone  in  1  core completion flag.
- CoreWen, CoreRen  in  1  core store/load enables. CoreAddr  in  AW. CoreWdat  in  DW.
- CoreRdat  out  DW  memory read data routed to the core.
- CoreRst  out  1  active-high hold-in-reset for the core program counter.
- MemWen, MemRen  out  1. MemAddr  out  AW. MemWdat  out  DW. MemRdat  in  DW: memory port. Reads are combinational; writes commit on the Clk edge.
- Busy  out  1  state is RUN. Finished  out  1  run ended by CoreDone. Timeout  out  1  run ended by watchdog.
- CycleCnt  out  CW  RUN cycles consumed by the last or current run.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, DONE:
  - Host owns memory. CoreRst=1.
  - Mem* = Host* gated by HostGnt.
  - HostGnt = HostReq & ~Start.
  - Core* inputs are ignored.
  - CoreRdat = MemRdat (don't-care).
- RUN:
  - Core owns memory. CoreRst=0. HostGnt=0.
  - Mem* = Core*. CoreRdat = MemRdat.
- IDLE/DONE -> RUN on Start=1:
  - CycleCnt, Finished and Timeout are cleared.
  - Start takes priority over a same-cycle HostReq; that host request is not granted.
- RUN, CycleCnt increments every cycle. At the edge:
  - CoreDone=1 -> DONE, Finished=1. The core store in this cycle commits.
  - CoreDone=0, Abort=1 -> IDLE, Finished=0, Timeout=0.
  - CoreDone=0, Abort=0, CycleCnt==MAX_CYCLES-1 -> DONE, Timeout=1.
  - Priority: CoreDone > Abort > watchdog.
- DONE persists until Start; Finished, Timeout and CycleCnt stay held.
- Granted host read: HostRdat <= MemRdat at the edge; HostRvalid=1 for exactly the next cycle.
- Granted host write: commits at the edge; no HostRvalid.
- Back-to-back host accesses are allowed every cycle.
- CycleCnt never wraps; the watchdog bounds it at MAX_CYCLES.

## Timing
- Reset (Reset=0, asynchronous):
  - State=IDLE, CoreRst=1.
  - Busy=0, Finished=0, Timeout=0, CycleCnt=0.
  - HostRvalid=0, HostRdat=0.
  - HostGnt, MemWen and MemRen fall combinationally.
- Reset mid-RUN: the in-flight core store is not committed. Reset mid host read: no HostRvalid.
- Start in cycle t:
  - RUN from t+1; core fetches PC 0 at t+1.
  - CoreDone seen in the k-th RUN cycle -> CycleCnt=k, Finished=1 from the next cycle.
- Watchdog: DONE with CycleCnt=MAX_CYCLES, Timeout=1, after exactly MAX_CYCLES RUN cycles.
- Host read latency: 1 cycle from grant to HostRvalid.
- Host request during RUN: stalls (HostGnt=0). It is granted in the first DONE/IDLE cycle.
- Start held high in DONE relaunches on the next edge. Start in RUN is ignored. Abort outside RUN is ignored.

## Test plan
- Reset asserted mid-RUN with CoreWen=1 -> IDLE immediately, CoreRst=1, Busy=0, CycleCnt=0, memory location unchanged.
- Host write 0x5A to addr 0x10 in IDLE, then read -> HostGnt=1 both cycles, HostRdat=0x5A with HostRvalid one cycle after the read grant.
- Start, CoreDone raised in the 7th RUN cycle with a core store of 0x3C to 0x20 in that cycle -> Finished=1, CycleCnt=7, host readback of 0x20 returns 0x3C.
- MAX_CYCLES=16, CoreDone never raised -> DONE after 16 RUN cycles, Timeout=1, Finished=0, CycleCnt=16; a second Start clears both flags.
- Start and HostReq in the same IDLE cycle -> HostGnt=0, RUN next cycle; host request held through RUN is granted in the first DONE cycle.
- CoreDone and Abort in the same RUN cycle -> DONE with Finished=1. Abort alone in cycle 3 -> IDLE, Finished=0, Timeout=0, CycleCnt=3.

Source files
------------

// File: rtl/run_sequencer.sv
// Run controller for the single-cycle core: holds the core in reset while the host
// owns data memory, launches runs, and stops them on completion, abort or watchdog.
module run_sequencer #(
   parameter int MAX_CYCLES = 4096,
   parameter int CW         = 16,
   parameter int AW         = 8,
   parameter int DW         = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic          abort_i,
   input  logic          host_req_i,
   input  logic          host_wr_i,
   input  logic [AW-1:0] host_addr_i,
   input  logic [DW-1:0] host_wdat_i,
   output logic          host_gnt_o,
   output logic [DW-1:0] host_rdat_o,
   output logic          host_rvalid_o,
   input  logic          core_done_i,
   input  logic          core_wen_i,
   input  logic          core_ren_i,
   input  logic [AW-1:0] core_addr_i,
   input  logic [DW-1:0] core_wdat_i,
   output logic [DW-1:0] core_rdat_o,
   output logic          core_rst_o,
   output logic          mem_wen_o,
   output logic          mem_ren_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdat_o,
   input  logic [DW-1:0] mem_rdat_i,
   output logic          busy_o,
   output logic          finished_o,
   output logic          timeout_o,
   output logic [CW-1:0] cycle_cnt_o,
   output logic [1:0]    state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_CYCLE = CW'(MAX_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   state_t        state_q;
   logic          busy_q;
   logic          core_rst_q;
   logic          finished_q;
   logic          timeout_q;
   logic [CW-1:0] cycle_cnt_q;
   logic [CW-1:0] cycle_cnt_d;
   logic [DW-1:0] host_rdat_q;
   logic          host_rvalid_q;
   logic          in_run;
   logic          host_gnt;
   logic          host_rd_gnt;

   // Reset gates every memory strobe so nothing commits while rst_ni is low.
   assign in_run      = (state_q == ST_RUN);
   assign host_gnt    = rst_ni & ~in_run & host_req_i & ~start_i;
   assign host_rd_gnt = host_gnt & ~host_wr_i;
   assign cycle_cnt_d = cycle_cnt_q + CNT_ONE;

   assign mem_wen_o  = rst_ni & (in_run ? core_wen_i : (host_gnt & host_wr_i));
   assign mem_ren_o  = rst_ni & (in_run ? core_ren_i : host_rd_gnt);
   assign mem_addr_o = in_run ? core_addr_i : host_addr_i;
   assign mem_wdat_o = in_run ? core_wdat_i : host_wdat_i;

   assign core_rdat_o   = mem_rdat_i;
   assign host_gnt_o    = host_gnt;
   assign host_rdat_o   = host_rdat_q;
   assign host_rvalid_o = host_rvalid_q;
   assign core_rst_o    = core_rst_q;
   assign busy_o        = busy_q;
   assign finished_o    = finished_q;
   assign timeout_o     = timeout_q;
   assign cycle_cnt_o   = cycle_cnt_q;
   assign state_o       = state_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         busy_q        <= 1'b0;
         core_rst_q    <= 1'b1;
         finished_q    <= 1'b0;
         timeout_q     <= 1'b0;
         cycle_cnt_q   <= '0;
         host_rdat_q   <= '0;
         host_rvalid_q <= 1'b0;
      end else begin
         host_rvalid_q <= host_rd_gnt;
         if (host_rd_gnt) begin
            host_rdat_q <= mem_rdat_i;
         end
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  state_q     <= ST_RUN;
                  busy_q      <= 1'b1;
                  core_rst_q  <= 1'b0;
                  finished_q  <= 1'b0;
                  timeout_q   <= 1'b0;
                  cycle_cnt_q <= '0;
               end
            end
            ST_RUN: begin
               cycle_cnt_q <= cycle_cnt_d;
               // Completion outranks abort, which outranks the watchdog.
               if (core_done_i) begin
                  state_q    <= ST_DONE;
                  busy_q     <= 1'b0;
                  core_rst_q <= 1'b1;
                  finished_q <= 1'b1;
               end else if (abort_i) begin
                  state_q    <= ST_IDLE;
                  busy_q     <= 1'b0;
                  core_rst_q <= 1'b1;
                  finished_q <= 1'b0;
                  timeout_q  <= 1'b0;
               end else if (cycle_cnt_q == LAST_CYCLE) begin
                  state_q    <= ST_DONE;
                  busy_q     <= 1'b0;
                  core_rst_q <= 1'b1;
                  timeout_q  <= 1'b1;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               busy_q     <= 1'b0;
               core_rst_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: host memory traffic, directed and random runs, checked
// against an outcome model and a shadow copy of data memory.
module tb_run_sequencer;

   localparam int MAXC = 16;
   localparam int CW   = 16;
   localparam int AW   = 8;
   localparam int DW   = 8;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          start_i, abort_i;
   logic          host_req_i, host_wr_i;
   logic [AW-1:0] host_addr_i;
   logic [DW-1:0] host_wdat_i;
   logic          host_gnt_o;
   logic [DW-1:0] host_rdat_o;
   logic          host_rvalid_o;
   logic          core_done_i, core_wen_i, core_ren_i;
   logic [AW-1:0] core_addr_i;
   logic [DW-1:0] core_wdat_i;
   logic [DW-1:0] core_rdat_o;
   logic          core_rst_o;
   logic          mem_wen_o, mem_ren_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdat_o;
   logic [DW-1:0] mem_rdat_i;
   logic          busy_o, finished_o, timeout_o;
   logic [CW-1:0] cycle_cnt_o;
   logic [1:0]    state_o;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem     [256];
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] exp_q   [$];

   run_sequencer #(.MAX_CYCLES(MAXC), .CW(CW), .AW(AW), .DW(DW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
      .host_req_i(host_req_i), .host_wr_i(host_wr_i), .host_addr_i(host_addr_i),
      .host_wdat_i(host_wdat_i), .host_gnt_o(host_gnt_o), .host_rdat_o(host_rdat_o),
      .host_rvalid_o(host_rvalid_o), .core_done_i(core_done_i), .core_wen_i(core_wen_i),
      .core_ren_i(core_ren_i), .core_addr_i(core_addr_i), .core_wdat_i(core_wdat_i),
      .core_rdat_o(core_rdat_o), .core_rst_o(core_rst_o), .mem_wen_o(mem_wen_o),
      .mem_ren_o(mem_ren_o), .mem_addr_o(mem_addr_o), .mem_wdat_o(mem_wdat_o),
      .mem_rdat_i(mem_rdat_i), .busy_o(busy_o), .finished_o(finished_o),
      .timeout_o(timeout_o), .cycle_cnt_o(cycle_cnt_o), .state_o(state_o)
   );

   // Clock/reset and the external data memory
   always #5 clk_i = ~clk_i;

   assign mem_rdat_i = mem[mem_addr_o];
   always @(posedge clk_i) begin
      if (mem_wen_o) mem[mem_addr_o] <= mem_wdat_o;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      start_i = 0; abort_i = 0; host_req_i = 0; host_wr_i = 0;
      host_addr_i = '0; host_wdat_i = '0;
      core_done_i = 0; core_wen_i = 0; core_ren_i = 0; core_addr_i = '0; core_wdat_i = '0;
   endtask

   // Driver: one granted host write (request is left asserted for back-to-back use).
   task automatic host_write(input logic [7:0] a, input logic [7:0] d);
      host_req_i = 1; host_wr_i = 1; host_addr_i = a; host_wdat_i = d;
      #1;
      checks++; if (host_gnt_o !== 1'b1) begin errors++; $display("FAIL host_wr_gnt addr %0h got %0b want 1", a, host_gnt_o); end
      @(posedge clk_i);
      ref_mem[a] = d;
      #1;
   endtask

   // Outcome model: which event ends the run first, and in which RUN cycle.
   task automatic model_run(input int kd, input int ka, output int e, output logic fin,
                            output logic to, output logic idle);
      int ed, ea;
      ed = (kd > 0) ? kd : 1 << 30;
      ea = (ka > 0) ? ka : 1 << 30;
      e = MAXC;
      if (ea < e) e = ea;
      if (ed < e) e = ed;
      fin  = (e == kd);
      idle = !fin && (e == ka);
      to   = !fin && !idle;
   endtask

   // Driver: launch a run and feed the core side until the modelled end cycle.
   task automatic do_run(input int kd, input int ka, input logic st_en,
                         input logic [7:0] st_addr, input logic [7:0] st_data,
                         output int e, output logic fin, output logic to, output logic idle);
      model_run(kd, ka, e, fin, to, idle);
      start_i = 1;
      #1;
      checks++; if (host_gnt_o !== 1'b0) begin errors++; $display("FAIL start_gnt got %0b want 0", host_gnt_o); end
      @(posedge clk_i); #1;
      for (int j = 1; j <= e; j++) begin
         start_i     = 1'($urandom_range(0, 1));
         core_done_i = (j == kd);
         abort_i     = (j == ka);
         core_ren_i  = 1'($urandom_range(0, 1));
         core_addr_i = 8'($urandom_range(128, 255));
         core_wdat_i = 8'($urandom);
         core_wen_i  = ($urandom_range(0, 3) == 0);
         if (j == e && st_en) begin
            core_wen_i = 1; core_addr_i = st_addr; core_wdat_i = st_data;
         end
         #1;
         checks++; if (busy_o !== 1'b1 || core_rst_o !== 1'b0) begin errors++; $display("FAIL run_busy cycle %0d got busy %0b rst %0b want 1 0", j, busy_o, core_rst_o); end
         checks++; if (cycle_cnt_o !== 16'(j - 1)) begin errors++; $display("FAIL run_cnt cycle %0d got %0d want %0d", j, cycle_cnt_o, j - 1); end
         checks++; if (host_gnt_o !== 1'b0 || mem_wen_o !== core_wen_i || mem_ren_o !== core_ren_i) begin errors++; $display("FAIL run_mem cycle %0d gnt %0b wen %0b ren %0b want 0 %0b %0b", j, host_gnt_o, mem_wen_o, mem_ren_o, core_wen_i, core_ren_i); end
         checks++; if (core_rdat_o !== ref_mem[core_addr_i]) begin errors++; $display("FAIL run_rdat addr %0h got %0h want %0h", core_addr_i, core_rdat_o, ref_mem[core_addr_i]); end
         @(posedge clk_i);
         if (core_wen_i) ref_mem[core_addr_i] = core_wdat_i;
         #1;
      end
      start_i = 0; abort_i = 0; core_done_i = 0; core_wen_i = 0; core_ren_i = 0;
   endtask

   task automatic test_reset();
      host_req_i = 1; host_wr_i = 1;
      repeat (2) @(posedge clk_i);
      #1;
      checks++; if (core_rst_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL reset_ctrl rst %0b busy %0b want 1 0", core_rst_o, busy_o); end
      checks++; if (finished_o !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("FAIL reset_flags fin %0b to %0b want 0 0", finished_o, timeout_o); end
      checks++; if (cycle_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cycle_cnt_o); end
      checks++; if (host_rvalid_o !== 1'b0 || host_rdat_o !== 8'h00) begin errors++; $display("FAIL reset_rd rvalid %0b rdat %0h want 0 0", host_rvalid_o, host_rdat_o); end
      checks++; if (host_gnt_o !== 1'b0 || mem_wen_o !== 1'b0 || mem_ren_o !== 1'b0) begin errors++; $display("FAIL reset_strobes gnt %0b wen %0b ren %0b want 0", host_gnt_o, mem_wen_o, mem_ren_o); end
      host_req_i = 0; host_wr_i = 0;
      rst_ni = 1;
      tick();
   endtask

   task automatic test_host_rw();
      logic [7:0] a;
      host_write(8'h10, 8'h5A);
      host_wr_i = 0; host_addr_i = 8'h10;
      #1;
      checks++; if (host_gnt_o !== 1'b1 || mem_ren_o !== 1'b1) begin errors++; $display("FAIL host_rd_gnt gnt %0b ren %0b want 1 1", host_gnt_o, mem_ren_o); end
      @(posedge clk_i); #1;
      host_req_i = 0;
      checks++; if (host_rvalid_o !== 1'b1 || host_rdat_o !== 8'h5A) begin errors++; $display("FAIL host_rd_data rvalid %0b rdat %0h want 1 5a", host_rvalid_o, host_rdat_o); end
      tick();
      checks++; if (host_rvalid_o !== 1'b0) begin errors++; $display("FAIL host_rvalid_pulse got %0b want 0", host_rvalid_o); end
      // back-to-back mix of random writes and reads
      for (int i = 0; i < 16; i++) begin
         a = 8'($urandom_range(0, 15));
         host_req_i = 1; host_addr_i = a; host_wdat_i = 8'($urandom);
         host_wr_i = 1'($urandom_range(0, 1));
         if (!host_wr_i) exp_q.push_back(ref_mem[a]);
         @(posedge clk_i);
         if (host_wr_i) ref_mem[a] = host_wdat_i;
         #1;
         if (host_wr_i) begin
            checks++; if (host_rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_wr_rvalid step %0d got %0b want 0", i, host_rvalid_o); end
         end else begin
            checks++; if (host_rvalid_o !== 1'b1 || host_rdat_o !== exp_q[0]) begin errors++; $display("FAIL b2b_rd step %0d rvalid %0b rdat %0h want 1 %0h", i, host_rvalid_o, host_rdat_o, exp_q[0]); end
            void'(exp_q.pop_front());
         end
      end
      host_req_i = 0; host_wr_i = 0;
      tick();
   endtask

   task automatic test_done();
      int e; logic fin, to, idle;
      do_run(7, 0, 1'b1, 8'h20, 8'h3C, e, fin, to, idle);
      checks++; if (finished_o !== 1'b1 || timeout_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL done_flags fin %0b to %0b busy %0b want 1 0 0", finished_o, timeout_o, busy_o); end
      checks++; if (cycle_cnt_o !== 16'd7) begin errors++; $display("FAIL done_cnt got %0d want 7", cycle_cnt_o); end
      tick();
      checks++; if (finished_o !== 1'b1 || cycle_cnt_o !== 16'd7 || core_rst_o !== 1'b1) begin errors++; $display("FAIL done_hold fin %0b cnt %0d rst %0b want 1 7 1", finished_o, cycle_cnt_o, core_rst_o); end
      host_req_i = 1; host_wr_i = 0; host_addr_i = 8'h20;
      @(posedge clk_i); #1;
      host_req_i = 0;
      checks++; if (host_rvalid_o !== 1'b1 || host_rdat_o !== 8'h3C) begin errors++; $display("FAIL done_readback rvalid %0b rdat %0h want 1 3c", host_rvalid_o, host_rdat_o); end
      tick();
   endtask

   task automatic test_watchdog();
      int e; logic fin, to, idle;
      do_run(0, 0, 1'b0, 8'h00, 8'h00, e, fin, to, idle);
      checks++; if (timeout_o !== 1'b1 || finished_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL wd_flags to %0b fin %0b busy %0b want 1 0 0", timeout_o, finished_o, busy_o); end
      checks++; if (cycle_cnt_o !== 16'(MAXC)) begin errors++; $display("FAIL wd_cnt got %0d want %0d", cycle_cnt_o, MAXC); end
      start_i = 1;
      tick();
      start_i = 0;
      checks++; if (timeout_o !== 1'b0 || finished_o !== 1'b0 || cycle_cnt_o !== 16'd0 || busy_o !== 1'b1) begin errors++; $display("FAIL wd_restart to %0b fin %0b cnt %0d busy %0b want 0 0 0 1", timeout_o, finished_o, cycle_cnt_o, busy_o); end
      abort_i = 1;
      tick();
      abort_i = 0;
      checks++; if (busy_o !== 1'b0 || cycle_cnt_o !== 16'd1) begin errors++; $display("FAIL wd_abort busy %0b cnt %0d want 0 1", busy_o, cycle_cnt_o); end
   endtask

   task automatic test_start_priority();
      int e; logic fin, to, idle;
      host_req_i = 1; host_wr_i = 0; host_addr_i = 8'h20;
      do_run(4, 0, 1'b0, 8'h00, 8'h00, e, fin, to, idle);
      #1;
      checks++; if (host_gnt_o !== 1'b1) begin errors++; $display("FAIL prio_first_done_gnt got %0b want 1", host_gnt_o); end
      @(posedge clk_i); #1;
      host_req_i = 0;
      checks++; if (host_rvalid_o !== 1'b1 || host_rdat_o !== ref_mem[8'h20]) begin errors++; $display("FAIL prio_read rvalid %0b rdat %0h want 1 %0h", host_rvalid_o, host_rdat_o, ref_mem[8'h20]); end
      tick();
   endtask

   task automatic test_done_abort();
      int e; logic fin, to, idle;
      do_run(5, 5, 1'b0, 8'h00, 8'h00, e, fin, to, idle);
      checks++; if (finished_o !== 1'b1 || timeout_o !== 1'b0 || cycle_cnt_o !== 16'd5) begin errors++; $display("FAIL both_flags fin %0b to %0b cnt %0d want 1 0 5", finished_o, timeout_o, cycle_cnt_o); end
      do_run(0, 3, 1'b0, 8'h00, 8'h00, e, fin, to, idle);
      checks++; if (finished_o !== 1'b0 || timeout_o !== 1'b0 || cycle_cnt_o !== 16'd3 || busy_o !== 1'b0) begin errors++; $display("FAIL abort_flags fin %0b to %0b cnt %0d busy %0b want 0 0 3 0", finished_o, timeout_o, cycle_cnt_o, busy_o); end
      abort_i = 1;
      tick();
      abort_i = 0;
      checks++; if (busy_o !== 1'b0 || cycle_cnt_o !== 16'd3 || core_rst_o !== 1'b1) begin errors++; $display("FAIL abort_idle_ignored busy %0b cnt %0d rst %0b want 0 3 1", busy_o, cycle_cnt_o, core_rst_o); end
   endtask

   task automatic test_random_runs();
      int e; logic fin, to, idle;
      logic [7:0] a;
      for (int r = 0; r < 8; r++) begin
         do_run($urandom_range(0, 20), $urandom_range(0, 20), 1'b0, 8'h00, 8'h00, e, fin, to, idle);
         checks++; if (finished_o !== fin || timeout_o !== to || cycle_cnt_o !== 16'(e) || busy_o !== 1'b0) begin errors++; $display("FAIL rnd_outcome run %0d fin %0b to %0b cnt %0d busy %0b want %0b %0b %0d 0", r, finished_o, timeout_o, cycle_cnt_o, busy_o, fin, to, e); end
         for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(128, 255));
            host_req_i = 1; host_wr_i = 0; host_addr_i = a;
            exp_q.push_back(ref_mem[a]);
            @(posedge clk_i); #1;
            checks++; if (host_rvalid_o !== 1'b1 || host_rdat_o !== exp_q[0]) begin errors++; $display("FAIL rnd_readback addr %0h rvalid %0b rdat %0h want 1 %0h", a, host_rvalid_o, host_rdat_o, exp_q[0]); end
            void'(exp_q.pop_front());
         end
         host_req_i = 0;
         tick();
      end
   endtask

   task automatic test_reset_mid_run();
      host_write(8'h30, 8'h11);
      host_req_i = 0;
      start_i = 1;
      tick();
      start_i = 0;
      repeat (2) tick();
      core_wen_i = 1; core_addr_i = 8'h30; core_wdat_i = 8'hEE;
      #1;
      rst_ni = 0;
      #1;
      checks++; if (busy_o !== 1'b0 || core_rst_o !== 1'b1 || cycle_cnt_o !== 16'd0 || mem_wen_o !== 1'b0) begin errors++; $display("FAIL rst_run busy %0b rst %0b cnt %0d wen %0b want 0 1 0 0", busy_o, core_rst_o, cycle_cnt_o, mem_wen_o); end
      @(posedge clk_i); #1;
      core_wen_i = 0;
      rst_ni = 1;
      tick();
      host_req_i = 1; host_wr_i = 0; host_addr_i = 8'h30;
      @(posedge clk_i); #1;
      checks++; if (host_rvalid_o !== 1'b1 || host_rdat_o !== 8'h11) begin errors++; $display("FAIL rst_run_mem rvalid %0b rdat %0h want 1 11", host_rvalid_o, host_rdat_o); end
      // reset lands between a read grant and its edge
      #1;
      rst_ni = 0;
      #1;
      checks++; if (host_gnt_o !== 1'b0 || mem_ren_o !== 1'b0) begin errors++; $display("FAIL rst_rd_gnt gnt %0b ren %0b want 0 0", host_gnt_o, mem_ren_o); end
      @(posedge clk_i); #1;
      host_req_i = 0;
      rst_ni = 1;
      checks++; if (host_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rd_rvalid got %0b want 0", host_rvalid_o); end
      tick();
      checks++; if (host_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rd_rvalid_late got %0b want 0", host_rvalid_o); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      idle_inputs();
      rst_ni = 1;
      #2;
      rst_ni = 0;
      test_reset();
      test_host_rw();
      test_done();
      test_watchdog();
      test_start_priority();
      test_done_abort();
      test_random_runs();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
